// File: rtl/aes_word_loader.sv
`timescale 1ns/1ps
// Word-stream front-end for the AES-128 core: assembles key and plaintext from 32-bit words,
// launches the core, waits a fixed latency and holds the captured result behind valid/ready.
module aes_word_loader #(
  parameter int unsigned CORE_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sel,
  input  logic [31:0]  in_data,
  output logic [127:0] core_plaintext,
  output logic [127:0] core_key,
  input  logic [127:0] core_cipher_text,
  input  logic [127:0] core_keyout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_cipher,
  output logic [127:0] out_keyout,
  output logic         key_valid,
  output logic         busy
);

  typedef enum logic [1:0] {StFill, StWait, StOut} state_e;

  state_e       state;
  logic [127:0] pt_buf;
  logic [127:0] key_buf;
  logic [2:0]   pt_cnt;
  logic [2:0]   key_cnt;
  logic [5:0]   lat_cnt;
  logic         launch;
  logic         accept;

  assign launch   = (state == StFill) && (pt_cnt == 3'd4) && (key_cnt == 3'd4);
  // Key words are always welcome in FILL; only a fifth plaintext word stalls.
  assign in_ready = rst_n && (state == StFill) && !launch && !(!in_sel && (pt_cnt == 3'd4));
  assign accept   = in_valid && in_ready;
  assign busy     = (state != StFill);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= StFill;
      pt_buf         <= '0;
      key_buf        <= '0;
      pt_cnt         <= '0;
      key_cnt        <= '0;
      lat_cnt        <= '0;
      key_valid      <= 1'b0;
      core_plaintext <= '0;
      core_key       <= '0;
      out_valid      <= 1'b0;
      out_cipher     <= '0;
      out_keyout     <= '0;
    end else begin
      case (state)
        StFill: begin
          if (launch) begin
            core_plaintext <= pt_buf;
            core_key       <= key_buf;
            lat_cnt        <= 6'(CORE_LATENCY - 1);
            state          <= StWait;
          end else if (accept) begin
            if (in_sel) begin
              if (key_cnt == 3'd4) begin
                // A fresh key group invalidates the held key immediately.
                key_buf[127:96] <= in_data;
                key_cnt         <= 3'd1;
                key_valid       <= 1'b0;
              end else begin
                for (int i = 0; i < 4; i++) begin
                  if (key_cnt == 3'(i)) key_buf[(3 - i) * 32 +: 32] <= in_data;
                end
                key_cnt <= key_cnt + 3'd1;
                if (key_cnt == 3'd3) key_valid <= 1'b1;
              end
            end else begin
              for (int i = 0; i < 4; i++) begin
                if (pt_cnt == 3'(i)) pt_buf[(3 - i) * 32 +: 32] <= in_data;
              end
              pt_cnt <= pt_cnt + 3'd1;
            end
          end
        end
        StWait: begin
          if (lat_cnt == 6'd0) begin
            out_cipher <= core_cipher_text;
            out_keyout <= core_keyout;
            out_valid  <= 1'b1;
            state      <= StOut;
          end else begin
            lat_cnt <= lat_cnt - 6'd1;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pt_cnt    <= 3'd0;
            state     <= StFill;
          end
        end
        default: state <= StFill;
      endcase
    end
  end

endmodule
